// File: rtl/nf10_axis_traffic_gen_chk.sv
// AXI4-Stream loopback traffic generator and checker: numbered packets out on m_axis, verification and statistics on s_axis.
// Optional macro AXIS_GC_RX_THROTTLE_EN: pseudo-random s_axis_tready backpressure from a 16-bit LFSR.
module nf10_axis_traffic_gen_chk #(
    parameter int C_DATA_WIDTH  = 64,
    parameter int C_TUSER_WIDTH = 128,
    parameter int C_LEN_WIDTH   = 16,
    parameter int C_CNT_WIDTH   = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       gen_en,
    input  logic [C_LEN_WIDTH-1:0]     gen_len_min,
    input  logic [C_LEN_WIDTH-1:0]     gen_len_max,
    input  logic [C_LEN_WIDTH-1:0]     gen_ifg,
    input  logic [C_CNT_WIDTH-1:0]     gen_pkt_limit,
    input  logic                       cnt_clr,
    output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [C_CNT_WIDTH-1:0]     tx_pkt_cnt,
    output logic [C_CNT_WIDTH-1:0]     rx_pkt_cnt,
    output logic [C_CNT_WIDTH-1:0]     rx_err_cnt,
    output logic                       gen_done
);
    localparam int NW = C_DATA_WIDTH / 32;
    localparam int SW = C_DATA_WIDTH / 8;

    function automatic logic [C_DATA_WIDTH-1:0] pattern(input logic [15:0] seq, input logic [15:0] beat);
        return {NW{seq, beat}};
    endfunction

    function automatic logic [15:0] beat_bytes(input logic [C_LEN_WIDTH-1:0] n);
        return 16'(32'(n) * 32'(SW));
    endfunction

    typedef enum logic [1:0] {G_IDLE, G_SEND, G_IFG} gst_t;

    gst_t                     gst_q;
    logic [C_LEN_WIDTH-1:0]   beat_q, len_q, len_cur_q, ifg_q;
    logic [15:0]              seq_q;
    logic                     tvalid_q, tlast_q;
    logic [C_DATA_WIDTH-1:0]  tdata_q;
    logic [C_TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic [C_CNT_WIDTH-1:0]   tx_cnt_q;
    logic [C_LEN_WIDTH-1:0]   len_pick, len_use, len_nxt, beat_nxt;
    logic                     tx_done;

    always_comb begin
        if (gen_len_min >= gen_len_max || len_cur_q < gen_len_min || len_cur_q > gen_len_max)
            len_pick = gen_len_min;
        else
            len_pick = len_cur_q;
        len_use = (len_pick == '0) ? C_LEN_WIDTH'(1) : len_pick;
        len_nxt = (gen_len_min >= gen_len_max || len_pick >= gen_len_max) ? gen_len_min : len_pick + 1'b1;
        beat_nxt = beat_q + 1'b1;
        tuser_d = '0;
        tuser_d[15:0] = beat_bytes(len_use);
    end

    assign gen_done = (gen_pkt_limit != '0) && (tx_cnt_q >= gen_pkt_limit);
    assign tx_done  = (gst_q == G_SEND) && tvalid_q && tlast_q && m_axis_tready;

    // Outputs hold while stalled: only a handshake moves the FSM in SEND.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            gst_q     <= G_IDLE;
            beat_q    <= '0;
            len_q     <= '0;
            len_cur_q <= gen_len_min;
            ifg_q     <= '0;
            seq_q     <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            tuser_q   <= '0;
        end else begin
            case (gst_q)
                G_IDLE: if (gen_en && !gen_done) begin
                    gst_q     <= G_SEND;
                    len_q     <= len_use;
                    len_cur_q <= len_nxt;
                    beat_q    <= '0;
                    tvalid_q  <= 1'b1;
                    tlast_q   <= (len_use == C_LEN_WIDTH'(1));
                    tdata_q   <= pattern(seq_q, 16'h0);
                    tuser_q   <= tuser_d;
                end
                G_SEND: if (m_axis_tready) begin
                    if (tlast_q) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        seq_q    <= seq_q + 1'b1;
                        // The IDLE turnaround is the last cycle of the gap.
                        if (gen_ifg > C_LEN_WIDTH'(1)) begin
                            gst_q <= G_IFG;
                            ifg_q <= gen_ifg - 1'b1;
                        end else begin
                            gst_q <= G_IDLE;
                        end
                    end else begin
                        beat_q  <= beat_nxt;
                        tlast_q <= (beat_nxt == len_q - 1'b1);
                        tdata_q <= pattern(seq_q, 16'(beat_nxt));
                    end
                end
                G_IFG: begin
                    if (ifg_q <= C_LEN_WIDTH'(1)) gst_q <= G_IDLE;
                    else                          ifg_q <= ifg_q - 1'b1;
                end
                default: gst_q <= G_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || cnt_clr)       tx_cnt_q <= '0;
        else if (tx_done && ~&tx_cnt_q) tx_cnt_q <= tx_cnt_q + 1'b1;
    end

    logic                   rx_first_q, rx_bad_q, synced_q;
    logic [C_LEN_WIDTH-1:0] rx_beat_q, rx_beats;
    logic [15:0]            rx_seq_q, exp_seq_q, rx_bytes_q;
    logic [C_CNT_WIDTH-1:0] rx_cnt_q, err_cnt_q;
    logic                   rx_acc, beat_sat, beat_bad, pkt_bad;
    logic [15:0]            word_seq, pkt_seq, ref_bytes;
    logic                   unused_tuser;

    assign unused_tuser = &{1'b0, s_axis_tuser};

    always_comb begin
        rx_acc    = s_axis_tvalid && s_axis_tready;
        word_seq  = s_axis_tdata[31:16];
        pkt_seq   = rx_first_q ? (synced_q ? exp_seq_q : word_seq) : rx_seq_q;
        ref_bytes = rx_first_q ? s_axis_tuser[15:0] : rx_bytes_q;
        beat_sat  = &rx_beat_q;
        rx_beats  = rx_beat_q + 1'b1;
        beat_bad  = (s_axis_tdata != pattern(pkt_seq, 16'(rx_beat_q))) || (s_axis_tstrb != '1) ||
                    (beat_sat && !s_axis_tlast) ||
                    (s_axis_tlast && (ref_bytes != beat_bytes(rx_beats)));
        pkt_bad   = rx_bad_q || beat_bad;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rx_first_q <= 1'b1;
            rx_bad_q   <= 1'b0;
            synced_q   <= 1'b0;
            rx_beat_q  <= '0;
            rx_seq_q   <= '0;
            exp_seq_q  <= '0;
            rx_bytes_q <= '0;
            rx_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (rx_acc) begin
                if (rx_first_q) begin
                    rx_seq_q   <= word_seq;
                    rx_bytes_q <= s_axis_tuser[15:0];
                end
                if (s_axis_tlast) begin
                    rx_first_q <= 1'b1;
                    rx_bad_q   <= 1'b0;
                    rx_beat_q  <= '0;
                    exp_seq_q  <= (rx_first_q ? word_seq : rx_seq_q) + 1'b1;
                    synced_q   <= 1'b1;
                end else begin
                    rx_first_q <= 1'b0;
                    rx_bad_q   <= pkt_bad;
                    if (!beat_sat) rx_beat_q <= rx_beats;
                end
            end
            // Clear wins over a coincident increment and forces the next sequence to be adopted.
            if (cnt_clr) begin
                rx_cnt_q  <= '0;
                err_cnt_q <= '0;
                synced_q  <= 1'b0;
            end else if (rx_acc && s_axis_tlast) begin
                if (~&rx_cnt_q)              rx_cnt_q  <= rx_cnt_q + 1'b1;
                if (pkt_bad && ~&err_cnt_q)  err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

`ifdef AXIS_GC_RX_THROTTLE_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge aclk) begin
        if (!aresetn) lfsr_q <= 16'hACE1;
        else          lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    assign s_axis_tready = lfsr_q[0];
`else
    assign s_axis_tready = 1'b1;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tstrb  = '1;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign tx_pkt_cnt    = tx_cnt_q;
    assign rx_pkt_cnt    = rx_cnt_q;
    assign rx_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_nf10_axis_traffic_gen_chk.sv
// Directed bench for nf10_axis_traffic_gen_chk: generator timing, loopback checking, errors, backpressure, clear and reset.
module tb_nf10_axis_traffic_gen_chk;
    localparam int DW = 64, TU = 128, LW = 16, CW = 32;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0, gen_en = 1'b0, cnt_clr = 1'b0;
    logic [LW-1:0]   gen_len_min = '0, gen_len_max = '0, gen_ifg = '0;
    logic [CW-1:0]   gen_pkt_limit = '0;
    logic [DW-1:0]   m_axis_tdata, s_axis_tdata;
    logic [DW/8-1:0] m_axis_tstrb, s_axis_tstrb;
    logic [TU-1:0]   m_axis_tuser, s_axis_tuser;
    logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic            s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [CW-1:0]   tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt;
    logic            gen_done;

    logic tb_rdy = 1'b1, lb_en = 1'b0;
    int   flip_seq = -1, drop_seq = -1;
    int   checks = 0, errors = 0;

    int          cyc, mon_beat, mon_seq, mon_bad, tv_cycles;
    int          pkt_len[$], pkt_start[$], pkt_end[$];
    logic [15:0] pkt_tuser[$];

    nf10_axis_traffic_gen_chk #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(TU), .C_LEN_WIDTH(LW), .C_CNT_WIDTH(CW)) dut (
        .aclk(aclk), .aresetn(aresetn), .gen_en(gen_en), .gen_len_min(gen_len_min), .gen_len_max(gen_len_max),
        .gen_ifg(gen_ifg), .gen_pkt_limit(gen_pkt_limit), .cnt_clr(cnt_clr),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .rx_err_cnt(rx_err_cnt), .gen_done(gen_done)
    );

    // Loopback path with bench-side stall, drop and single-bit corruption.
    assign m_axis_tready = tb_rdy && (!lb_en || s_axis_tready);
    assign s_axis_tvalid = lb_en && tb_rdy && m_axis_tvalid &&
                           !(drop_seq >= 0 && m_axis_tdata[31:16] == 16'(drop_seq));
    assign s_axis_tdata  = m_axis_tdata ^ ((flip_seq >= 0 && m_axis_tdata[31:16] == 16'(flip_seq) &&
                           m_axis_tdata[15:0] == 16'd1) ? 64'h80 : 64'h0);
    assign s_axis_tstrb  = m_axis_tstrb;
    assign s_axis_tuser  = m_axis_tuser;
    assign s_axis_tlast  = m_axis_tlast;

    initial forever #5 aclk = ~aclk;

    initial begin
        logic [31:0] w;
        cyc = 0; mon_beat = 0; mon_seq = 0; mon_bad = 0; tv_cycles = 0;
        forever begin
            @(negedge aclk);
            cyc++;
            if (!aresetn) begin
                mon_beat = 0; mon_seq = 0;
            end else begin
                if (m_axis_tvalid) tv_cycles++;
                if (m_axis_tvalid && m_axis_tready) begin
                    w = {16'(mon_seq), 16'(mon_beat)};
                    if (mon_beat == 0) pkt_start.push_back(cyc);
                    if (m_axis_tdata !== {2{w}} || m_axis_tstrb !== 8'hFF) mon_bad++;
                    if (m_axis_tlast) begin
                        pkt_len.push_back(mon_beat + 1);
                        pkt_tuser.push_back(m_axis_tuser[15:0]);
                        pkt_end.push_back(cyc);
                        mon_beat = 0; mon_seq++;
                    end else mon_beat++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge aclk); #1;
    endtask

    task automatic do_reset(input int mn, input int mx, input int ifg, input int lim, input bit lb);
        gen_en = 0; cnt_clr = 0; tb_rdy = 1; lb_en = lb; flip_seq = -1; drop_seq = -1;
        gen_len_min = 16'(mn); gen_len_max = 16'(mx); gen_ifg = 16'(ifg); gen_pkt_limit = 32'(lim);
        aresetn = 0;
        repeat (2) tick();
        pkt_len.delete(); pkt_start.delete(); pkt_end.delete(); pkt_tuser.delete();
        mon_bad = 0; tv_cycles = 0;
        aresetn = 1;
        tick();
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk);
            if (rx_pkt_cnt == 32'(n)) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        do_reset(4, 4, 5, 3, 0);
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tuser !== '0) begin errors++; $display("FAIL rst_tuser got %h want 0", m_axis_tuser); end
        checks++; if (m_axis_tstrb !== 8'hFF) begin errors++; $display("FAIL rst_tstrb got %h want ff", m_axis_tstrb); end
        checks++; if ({tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt} !== '0) begin errors++;
            $display("FAIL rst_counters got %0d/%0d/%0d want 0/0/0", tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt); end
        checks++; if (gen_done !== 1'b0) begin errors++; $display("FAIL rst_gen_done got %b want 0", gen_done); end
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_s_tready got %b want 1", s_axis_tready); end
    endtask

    task automatic test_fixed_len;
        bit ok;
        do_reset(4, 4, 5, 3, 0);
        gen_en = 1;
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t1_early_tvalid got %b want 0", m_axis_tvalid); end
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h0 || m_axis_tuser[15:0] !== 16'd32) begin errors++;
            $display("FAIL t1_first_beat got v=%b d=%h u=%0d want v=1 d=0 u=32", m_axis_tvalid, m_axis_tdata, m_axis_tuser[15:0]); end
        ok = 0;
        for (int i = 0; i < 300; i++) begin tick(); if (gen_done) begin ok = 1; break; end end
        checks++; if (!ok) begin errors++; $display("FAIL t1_timeout gen_done got 0 want 1"); end
        repeat (20) tick();
        checks++; if (pkt_len.size() != 3) begin errors++; $display("FAIL t1_pkt_count got %0d want 3", pkt_len.size()); end
        for (int i = 0; i < pkt_len.size(); i++) begin
            checks++; if (pkt_len[i] != 4 || pkt_tuser[i] !== 16'd32) begin errors++;
                $display("FAIL t1_pkt%0d got len=%0d tuser=%0d want 4/32", i, pkt_len[i], pkt_tuser[i]); end
        end
        for (int i = 0; i + 1 < pkt_start.size() && i < pkt_end.size(); i++) begin
            checks++; if (pkt_start[i+1] - pkt_end[i] - 1 != 5) begin errors++;
                $display("FAIL t1_gap%0d got %0d want 5", i, pkt_start[i+1] - pkt_end[i] - 1); end
        end
        checks++; if (tx_pkt_cnt !== 32'd3 || gen_done !== 1'b1) begin errors++;
            $display("FAIL t1_done got tx=%0d done=%b want 3/1", tx_pkt_cnt, gen_done); end
        checks++; if (tv_cycles != 12) begin errors++; $display("FAIL t1_tvalid_cycles got %0d want 12", tv_cycles); end
        checks++; if (mon_bad != 0) begin errors++; $display("FAIL t1_payload got %0d bad beats want 0", mon_bad); end
        gen_en = 0;
    endtask

    task automatic test_len_sweep;
        int exp_len[5] = '{2, 3, 4, 2, 3};
        bit ok;
        do_reset(2, 4, 0, 5, 1);
        gen_en = 1;
        wait_rx(5, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t2_timeout rx_pkt_cnt got %0d want 5", rx_pkt_cnt); end
        repeat (5) tick();
        checks++; if (pkt_len.size() != 5) begin errors++; $display("FAIL t2_pkt_count got %0d want 5", pkt_len.size()); end
        for (int i = 0; i < 5 && i < pkt_len.size(); i++) begin
            checks++; if (pkt_len[i] != exp_len[i] || pkt_tuser[i] !== 16'(exp_len[i] * 8)) begin errors++;
                $display("FAIL t2_pkt%0d got len=%0d tuser=%0d want %0d/%0d", i, pkt_len[i], pkt_tuser[i], exp_len[i], exp_len[i] * 8); end
        end
        checks++; if (rx_pkt_cnt !== 32'd5 || rx_err_cnt !== 32'd0 || tx_pkt_cnt !== 32'd5) begin errors++;
            $display("FAIL t2_counts got tx=%0d rx=%0d err=%0d want 5/5/0", tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt); end
        checks++; if (mon_bad != 0) begin errors++; $display("FAIL t2_payload got %0d bad beats want 0", mon_bad); end
        gen_en = 0;
    endtask

    task automatic test_corrupt;
        bit ok;
        do_reset(3, 3, 2, 5, 1);
        flip_seq = 2;
        gen_en = 1;
        wait_rx(3, 200, ok);
        checks++; if (!ok || rx_err_cnt !== 32'd1) begin errors++;
            $display("FAIL t3_after_pkt2 got rx=%0d err=%0d want 3/1", rx_pkt_cnt, rx_err_cnt); end
        wait_rx(5, 200, ok);
        repeat (3) tick();
        checks++; if (!ok || rx_pkt_cnt !== 32'd5 || rx_err_cnt !== 32'd1) begin errors++;
            $display("FAIL t3_final got rx=%0d err=%0d want 5/1", rx_pkt_cnt, rx_err_cnt); end
        gen_en = 0;
    endtask

    task automatic test_backpressure;
        logic          pv, pr;
        logic [DW-1:0] pd;
        int            stalls;
        do_reset(2, 4, 0, 4, 1);
        gen_en = 1; pv = 0; pr = 0; pd = '0; stalls = 0;
        for (int i = 0; i < 400 && rx_pkt_cnt != 32'd4; i++) begin
            tick();
            tb_rdy = ~tb_rdy;
            @(negedge aclk);
            if (pv && !pr) begin
                stalls++;
                checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd) begin errors++;
                    $display("FAIL t4_stall_hold got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, pd); end
            end
            pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata;
        end
        tb_rdy = 1;
        repeat (3) tick();
        checks++; if (stalls == 0) begin errors++; $display("FAIL t4_stalls got 0 want >0"); end
        checks++; if (rx_pkt_cnt !== 32'd4 || rx_err_cnt !== 32'd0 || mon_bad != 0) begin errors++;
            $display("FAIL t4_counts got rx=%0d err=%0d bad=%0d want 4/0/0", rx_pkt_cnt, rx_err_cnt, mon_bad); end
        gen_en = 0;
    endtask

    task automatic test_drop;
        bit ok;
        do_reset(2, 2, 1, 5, 1);
        drop_seq = 1;
        gen_en = 1;
        wait_rx(2, 200, ok);
        checks++; if (!ok || rx_err_cnt !== 32'd1) begin errors++;
            $display("FAIL t5_after_seq2 got rx=%0d err=%0d want 2/1", rx_pkt_cnt, rx_err_cnt); end
        wait_rx(4, 200, ok);
        repeat (5) tick();
        checks++; if (!ok || rx_pkt_cnt !== 32'd4 || rx_err_cnt !== 32'd1 || tx_pkt_cnt !== 32'd5) begin errors++;
            $display("FAIL t5_final got tx=%0d rx=%0d err=%0d want 5/4/1", tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt); end
        gen_en = 0;
    endtask

    task automatic test_clr_reset;
        bit ok;
        do_reset(4, 4, 3, 0, 1);
        gen_en = 1;
        wait_rx(2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t6_timeout rx_pkt_cnt got %0d want 2", rx_pkt_cnt); end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tlast) begin ok = 1; break; end
        end
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        @(negedge aclk);
        checks++; if (!ok || rx_pkt_cnt !== '0 || tx_pkt_cnt !== '0 || rx_err_cnt !== '0) begin errors++;
            $display("FAIL t6_clr got tx=%0d rx=%0d err=%0d want 0/0/0", tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt); end
        wait_rx(1, 100, ok);
        checks++; if (!ok || rx_err_cnt !== '0) begin errors++;
            $display("FAIL t6_resync got rx=%0d err=%0d want 1/0", rx_pkt_cnt, rx_err_cnt); end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tdata[15:0] == 16'd1) begin ok = 1; break; end
        end
        aresetn = 0;
        tick();
        @(negedge aclk);
        checks++; if (!ok || m_axis_tvalid !== 1'b0 || tx_pkt_cnt !== '0) begin errors++;
            $display("FAIL t6_reset_mid got v=%b tx=%0d want 0/0", m_axis_tvalid, tx_pkt_cnt); end
        gen_en = 0;
        aresetn = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_len();
        test_len_sweep();
        test_corrupt();
        test_backpressure();
        test_drop();
        test_clr_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
